// File: rtl/huff_decoder.sv
// Serial Huffman decoder: one stream bit per clock in, decoded symbols out over valid/ready.
// Build option HUFF_DEC_ERR_EN adds the dec_err pulse and the saturating err_cnt output.
module huff_decoder #(
  parameter int unsigned MAX_SYMS     = 5,
  parameter int unsigned MAX_CODE_LEN = 15,
  parameter int unsigned SYM_W        = 7,
  localparam int unsigned LEN_W       = $clog2(MAX_CODE_LEN + 1),
  localparam int unsigned IDX_W       = $clog2(MAX_SYMS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tbl_we,
  input  logic [IDX_W-1:0]        tbl_idx,
  input  logic [SYM_W-1:0]        tbl_sym,
  input  logic [LEN_W-1:0]        tbl_len,
  input  logic [MAX_CODE_LEN-1:0] tbl_code,
  input  logic                    tbl_clr,
  input  logic                    flush,
  input  logic                    bit_in,
  input  logic                    bit_valid,
  output logic                    bit_ready,
  output logic [SYM_W-1:0]        sym_out,
  output logic                    sym_valid,
  input  logic                    sym_ready,
  output logic                    busy,
  output logic [15:0]             sym_cnt,
  output logic                    dec_err
`ifdef HUFF_DEC_ERR_EN
  ,
  output logic [7:0]              err_cnt
`endif
);

  localparam int unsigned ACC_W = MAX_CODE_LEN - 1;
  localparam logic [MAX_CODE_LEN-1:0] MASK_ALL = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_EMIT} state_t;

  state_t                  r_state, w_state_nxt;
  logic [ACC_W-1:0]        r_acc, w_acc_nxt;
  logic [LEN_W-1:0]        r_len, w_len_nxt;
  logic [SYM_W-1:0]        r_sym_out, w_sym_out_nxt;
  logic                    r_sym_valid, w_sym_valid_nxt;
  logic [15:0]             r_sym_cnt, w_sym_cnt_nxt;
  logic                    r_bit_ready, r_busy;
  logic                    r_dec_err, w_dec_err_nxt;
`ifdef HUFF_DEC_ERR_EN
  logic [7:0]              r_err_cnt, w_err_cnt_nxt;
`endif

  logic [SYM_W-1:0]        r_tsym  [MAX_SYMS];
  logic [LEN_W-1:0]        r_tlen  [MAX_SYMS];
  logic [MAX_CODE_LEN-1:0] r_tcode [MAX_SYMS];

  logic [LEN_W-1:0]        w_nlen;
  logic [MAX_CODE_LEN-1:0] w_nacc;
  logic [MAX_CODE_LEN-1:0] w_mask;
  logic                    w_hit;
  logic [SYM_W-1:0]        w_hit_sym;

  // Candidate code after this bit; descending scan so the lowest matching entry wins.
  always_comb begin
    w_nlen    = r_len + LEN_W'(1);
    w_nacc    = {r_acc, bit_in};
    w_mask    = MASK_ALL >> (LEN_W'(MAX_CODE_LEN) - w_nlen);
    w_hit     = 1'b0;
    w_hit_sym = '0;
    for (int k = int'(MAX_SYMS) - 1; k >= 0; k--) begin
      if ((r_tlen[k] != '0) && (r_tlen[k] == w_nlen) &&
          ((r_tcode[k] & w_mask) == (w_nacc & w_mask))) begin
        w_hit     = 1'b1;
        w_hit_sym = r_tsym[k];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_len_nxt       = r_len;
    w_sym_out_nxt   = r_sym_out;
    w_sym_valid_nxt = r_sym_valid;
    w_sym_cnt_nxt   = r_sym_cnt;
    w_dec_err_nxt   = 1'b0;
`ifdef HUFF_DEC_ERR_EN
    w_err_cnt_nxt   = r_err_cnt;
`endif
    if (flush) begin
      w_state_nxt     = ST_IDLE;
      w_acc_nxt       = '0;
      w_len_nxt       = '0;
      w_sym_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ACCUM: begin
          if (bit_valid) begin
            if (w_hit) begin
              w_sym_out_nxt   = w_hit_sym;
              w_sym_valid_nxt = 1'b1;
              w_acc_nxt       = '0;
              w_len_nxt       = '0;
              w_state_nxt     = ST_EMIT;
            end else if (w_nlen == LEN_W'(MAX_CODE_LEN)) begin
              w_acc_nxt   = '0;
              w_len_nxt   = '0;
              w_state_nxt = ST_IDLE;
`ifdef HUFF_DEC_ERR_EN
              w_dec_err_nxt = 1'b1;
              if (r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
`endif
            end else begin
              w_acc_nxt   = w_nacc[ACC_W-1:0];
              w_len_nxt   = w_nlen;
              w_state_nxt = ST_ACCUM;
            end
          end
        end
        ST_EMIT: begin
          if (sym_ready) begin
            w_sym_valid_nxt = 1'b0;
            w_sym_cnt_nxt   = r_sym_cnt + 16'd1;
            w_state_nxt     = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_len       <= '0;
      r_sym_out   <= '0;
      r_sym_valid <= 1'b0;
      r_sym_cnt   <= '0;
      r_bit_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_dec_err   <= 1'b0;
`ifdef HUFF_DEC_ERR_EN
      r_err_cnt   <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_len       <= w_len_nxt;
      r_sym_out   <= w_sym_out_nxt;
      r_sym_valid <= w_sym_valid_nxt;
      r_sym_cnt   <= w_sym_cnt_nxt;
      r_bit_ready <= (w_state_nxt != ST_EMIT);
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_dec_err   <= w_dec_err_nxt;
`ifdef HUFF_DEC_ERR_EN
      r_err_cnt   <= w_err_cnt_nxt;
`endif
    end
  end

  // Code table: writable only while idle; out-of-range indices match no entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(MAX_SYMS); k++) begin
        r_tsym[k]  <= '0;
        r_tlen[k]  <= '0;
        r_tcode[k] <= '0;
      end
    end else if ((r_state == ST_IDLE) && !flush) begin
      if (tbl_clr) begin
        for (int k = 0; k < int'(MAX_SYMS); k++) r_tlen[k] <= '0;
      end else if (tbl_we) begin
        for (int k = 0; k < int'(MAX_SYMS); k++) begin
          if (tbl_idx == IDX_W'(k)) begin
            r_tsym[k]  <= tbl_sym;
            r_tlen[k]  <= tbl_len;
            r_tcode[k] <= tbl_code;
          end
        end
      end
    end
  end

  assign bit_ready = r_bit_ready;
  assign sym_out   = r_sym_out;
  assign sym_valid = r_sym_valid;
  assign busy      = r_busy;
  assign sym_cnt   = r_sym_cnt;
`ifdef HUFF_DEC_ERR_EN
  assign dec_err   = r_dec_err;
  assign err_cnt   = r_err_cnt;
`else
  assign dec_err   = 1'b0;
`endif

endmodule

// File: tb/tb_huff_decoder.sv
// Directed bench for huff_decoder: expected symbols queued at stimulus time, checked on handshake.
module tb_huff_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tbl_we, tbl_clr, flush, bit_in, bit_valid, sym_ready;
  logic [2:0]  tbl_idx;
  logic [6:0]  tbl_sym;
  logic [3:0]  tbl_len;
  logic [14:0] tbl_code;
  logic        bit_ready, sym_valid, busy, dec_err;
  logic [6:0]  sym_out;
  logic [15:0] sym_cnt;
`ifdef HUFF_DEC_ERR_EN
  logic [7:0]  err_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [6:0] exp_q[$];

  localparam logic [6:0] CH_A  = 7'h61;
  localparam logic [6:0] CH_E  = 7'h65;
  localparam logic [6:0] CH_SP = 7'h20;

  huff_decoder dut (
    .clk(clk), .rst_n(rst_n),
    .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_sym(tbl_sym), .tbl_len(tbl_len),
    .tbl_code(tbl_code), .tbl_clr(tbl_clr), .flush(flush),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .sym_out(sym_out), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .busy(busy), .sym_cnt(sym_cnt), .dec_err(dec_err)
`ifdef HUFF_DEC_ERR_EN
    , .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard on the pending handshake, then advance one clock and settle.
  task automatic step();
    logic [6:0] e;
    if (sym_valid === 1'b1 && sym_ready === 1'b1) begin
      chk("sym_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sym_out", 32'(sym_out), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] idx, input logic [6:0] s,
                      input logic [3:0] l, input logic [14:0] c);
    tbl_we = 1'b1; tbl_idx = idx; tbl_sym = s; tbl_len = l; tbl_code = c;
    step();
    tbl_we = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    int n = 0;
    bit_valid = 1'b1;
    bit_in    = b;
    while (bit_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) chk("bit_ready_timeout", 32'(bit_ready), 32'd1);
    step();
    bit_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic load_std();
    load(3'd0, CH_A, 4'd1, 15'b0);
    load(3'd1, CH_E, 4'd2, 15'b10);
    load(3'd2, CH_SP, 4'd2, 15'b11);
  endtask

  initial begin
    rst_n = 1'b0; tbl_we = 1'b0; tbl_clr = 1'b0; flush = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b0; sym_ready = 1'b1;
    tbl_idx = '0; tbl_sym = '0; tbl_len = '0; tbl_code = '0;
    #12;
    chk("rst_sym_valid", 32'(sym_valid), 32'd0);
    chk("rst_bit_ready", 32'(bit_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sym_cnt", 32'(sym_cnt), 32'd0);
    chk("rst_sym_out", 32'(sym_out), 32'd0);
    chk("rst_dec_err", 32'(dec_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: basic stream 0,10,11,0,0
    load_std();
    exp_q.push_back(CH_A);  send_bit(1'b0);
    exp_q.push_back(CH_E);  send_bit(1'b1); send_bit(1'b0);
    exp_q.push_back(CH_SP); send_bit(1'b1); send_bit(1'b1);
    exp_q.push_back(CH_A);  send_bit(1'b0);
    exp_q.push_back(CH_A);  send_bit(1'b0);
    drain();
    chk("t1_sym_cnt", 32'(sym_cnt), 32'd5);

    // 2: backpressure holds symbol and stalls the stream
    sym_ready = 1'b0;
    exp_q.push_back(CH_A); send_bit(1'b0);
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) begin
      chk("t2_bit_ready_low", 32'(bit_ready), 32'd0);
      chk("t2_valid_held", 32'(sym_valid), 32'd1);
      chk("t2_sym_held", 32'(sym_out), 32'(CH_A));
      step();
    end
    sym_ready = 1'b1;
    send_bit(1'b1);
    exp_q.push_back(CH_E); send_bit(1'b0);
    chk("t2_latency_valid", 32'(sym_valid), 32'd1);
    chk("t2_latency_sym", 32'(sym_out), 32'(CH_E));
    drain();
    chk("t2_sym_cnt", 32'(sym_cnt), 32'd7);

    // 3: flush drops partial code and a same-cycle bit
    send_bit(1'b1);
    chk("t3_busy_partial", 32'(busy), 32'd1);
    flush = 1'b1; bit_valid = 1'b1; bit_in = 1'b0;
    step();
    flush = 1'b0; bit_valid = 1'b0;
    chk("t3_busy_flushed", 32'(busy), 32'd0);
    chk("t3_valid_flushed", 32'(sym_valid), 32'd0);
    chk("t3_cnt_flush", 32'(sym_cnt), 32'd7);
    exp_q.push_back(CH_A); send_bit(1'b0);
    drain();
    step(); step();
    chk("t3_sym_cnt", 32'(sym_cnt), 32'd8);

    // 4: empty table overflows after 15 bits
    tbl_clr = 1'b1; step(); tbl_clr = 1'b0;
    for (int i = 0; i < 14; i++) send_bit(1'($urandom_range(1)));
    chk("t4_busy_14", 32'(busy), 32'd1);
    send_bit(1'b1);
    chk("t4_busy_after", 32'(busy), 32'd0);
    chk("t4_no_sym", 32'(sym_valid), 32'd0);
`ifdef HUFF_DEC_ERR_EN
    chk("t4_dec_err", 32'(dec_err), 32'd1);
    chk("t4_err_cnt", 32'(err_cnt), 32'd1);
    step();
    chk("t4_dec_err_pulse", 32'(dec_err), 32'd0);
`else
    chk("t4_dec_err_off", 32'(dec_err), 32'd0);
`endif
    chk("t4_sym_cnt", 32'(sym_cnt), 32'd8);

    // 5: table write in ACCUM ignored; reset mid-EMIT
    load(3'd0, CH_A, 4'd1, 15'b0);
    send_bit(1'b1);
    load(3'd1, CH_E, 4'd2, 15'b10);
    send_bit(1'b0);
    chk("t5_no_write_sym", 32'(sym_valid), 32'd0);
    chk("t5_still_accum", 32'(busy), 32'd1);
    flush = 1'b1; step(); flush = 1'b0;
    sym_ready = 1'b0;
    send_bit(1'b0);
    chk("t5_emit_valid", 32'(sym_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 32'(sym_valid), 32'd0);
    chk("t5_rst_bit_ready", 32'(bit_ready), 32'd1);
    chk("t5_rst_cnt", 32'(sym_cnt), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    sym_ready = 1'b1;
    send_bit(1'b0);
    chk("t5_tbl_cleared", 32'(sym_valid), 32'd0);
    chk("t5_tbl_cleared_busy", 32'(busy), 32'd1);
    flush = 1'b1; step(); flush = 1'b0;

    // 6: back-to-back all-'a' stream, one symbol every two cycles
    load(3'd0, CH_A, 4'd1, 15'b0);
    repeat (8) exp_q.push_back(CH_A);
    bit_valid = 1'b1; bit_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (i == 14) bit_valid = 1'b0;
    end
    chk("t6_q_empty_16cyc", 32'(exp_q.size()), 32'd0);
    chk("t6_sym_cnt", 32'(sym_cnt), 32'd8);
    chk("t6_idle", 32'(busy), 32'd0);
    step();
    chk("t6_no_extra", 32'(sym_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
